// File: rtl/mem_stage.sv
// Memory-access stage: drives the req/gnt/rvalid data bus, aligns load data and holds the MEM/WB register.
// Optional misaligned-access exception enabled by defining MEM_MISALIGN_EXP_EN.
module mem_stage #(
  parameter int XLEN          = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_flush,
  input  logic                     mem_valid,
  input  logic                     mem_re,
  input  logic                     mem_we,
  input  logic [XLEN-1:0]          mem_addr,
  input  logic [4:0]               mem_l_mask,
  input  logic [3:0]               mem_byte_we,
  input  logic [XLEN-1:0]          mem_wdata,
  input  logic                     mem_req_rf,
  input  logic [RF_ADDR_WIDTH-1:0] mem_rf_waddr,
  input  logic [XLEN-1:0]          mem_alu_res,
  output logic                     dbus_req,
  output logic                     dbus_we,
  output logic [XLEN-1:0]          dbus_addr,
  output logic [3:0]               dbus_be,
  output logic [XLEN-1:0]          dbus_wdata,
  input  logic                     dbus_gnt,
  input  logic                     dbus_rvalid,
  input  logic [XLEN-1:0]          dbus_rdata,
  output logic                     mem_stall,
  output logic                     mem_exp_flag,
  output logic [RF_ADDR_WIDTH-1:0] mem_fw_rd_addr,
  output logic [XLEN-1:0]          mem_fw_data,
  output logic                     wb_valid,
  output logic                     wb_req_rf,
  output logic [RF_ADDR_WIDTH-1:0] wb_rf_waddr,
  output logic [XLEN-1:0]          wb_rf_wdata
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP, DRAIN} state_e;

  state_e                   state_q, state_d;
  logic                     wb_valid_q, wb_req_rf_q;
  logic [RF_ADDR_WIDTH-1:0] wb_rf_waddr_q;
  logic [XLEN-1:0]          wb_rf_wdata_q;

  logic [2:0]      st_lanes;
  logic            misalign;
  logic            access;
  logic            wb_commit;
  logic [XLEN-1:0] load_data;

  function automatic logic [2:0] lane_cnt(input logic [3:0] be);
    return {2'b00, be[0]} + {2'b00, be[1]} + {2'b00, be[2]} + {2'b00, be[3]};
  endfunction

  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] rdata,
                                                   input logic [1:0]      off,
                                                   input logic [4:0]      lmask);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (lmask)
      5'b00001: return {{(XLEN-8){b[7]}}, b};
      5'b00010: return {{(XLEN-16){h[15]}}, h};
      5'b00100: return rdata;
      5'b01000: return {{(XLEN-8){1'b0}}, b};
      5'b10000: return {{(XLEN-16){1'b0}}, h};
      default:  return rdata;
    endcase
  endfunction

  // Store size is inferred from how many byte lanes EX enabled.
  function automatic logic [XLEN-1:0] store_replicate(input logic [XLEN-1:0] wdata,
                                                      input logic [2:0]      lanes);
    if (lanes == 3'd1)      return {4{wdata[7:0]}};
    else if (lanes == 3'd2) return {2{wdata[15:0]}};
    else                    return wdata;
  endfunction

  assign st_lanes = lane_cnt(mem_byte_we);

`ifdef MEM_MISALIGN_EXP_EN
  logic ld_half, ld_word;
  assign ld_half  = mem_l_mask[1] | mem_l_mask[4];
  assign ld_word  = mem_l_mask[2];
  assign misalign = mem_valid &
                    ((mem_re & ((ld_half & mem_addr[0]) | (ld_word & (|mem_addr[1:0])))) |
                     (mem_we & (((st_lanes == 3'd2) & mem_addr[0]) |
                                ((st_lanes == 3'd4) & (|mem_addr[1:0])))));
`else
  assign misalign = 1'b0;
`endif

  assign access    = mem_valid & (mem_re | mem_we) & ~misalign;
  assign wb_commit = mem_valid & ~pipe_flush & ~misalign;
  assign load_data = load_extract(dbus_rdata, mem_addr[1:0], mem_l_mask);

  assign mem_exp_flag   = misalign;
  assign dbus_we        = mem_we;
  assign dbus_addr      = {mem_addr[XLEN-1:2], 2'b00};
  assign dbus_be        = mem_byte_we;
  assign dbus_wdata     = store_replicate(mem_wdata, st_lanes);
  assign mem_fw_rd_addr = mem_rf_waddr;
  assign mem_fw_data    = mem_alu_res;

  // Stall covers every cycle of an access except the one where rvalid completes it.
  always_comb begin
    state_d   = state_q;
    dbus_req  = 1'b0;
    mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && !pipe_flush) begin
          dbus_req  = 1'b1;
          mem_stall = 1'b1;
          state_d   = dbus_gnt ? WAIT_RSP : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (pipe_flush) begin
          state_d = IDLE;
        end else begin
          dbus_req  = 1'b1;
          mem_stall = 1'b1;
          if (dbus_gnt) state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (dbus_rvalid) begin
          state_d = IDLE;
        end else begin
          mem_stall = 1'b1;
          if (pipe_flush) state_d = DRAIN;
        end
      end
      DRAIN: begin
        mem_stall = 1'b1;
        if (dbus_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // MEM/WB boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wb_valid_q    <= 1'b0;
      wb_req_rf_q   <= 1'b0;
      wb_rf_waddr_q <= '0;
      wb_rf_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (!mem_stall) begin
        wb_valid_q    <= wb_commit;
        wb_req_rf_q   <= mem_req_rf & wb_commit;
        wb_rf_waddr_q <= mem_rf_waddr;
        wb_rf_wdata_q <= mem_re ? load_data : mem_alu_res;
      end else begin
        wb_valid_q  <= 1'b0;
        wb_req_rf_q <= 1'b0;
      end
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_req_rf   = wb_req_rf_q;
  assign wb_rf_waddr = wb_rf_waddr_q;
  assign wb_rf_wdata = wb_rf_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver acts as pipeline and bus slave, monitor checks the WB register.
module tb_mem_stage;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst, pipe_flush, mem_valid, mem_re, mem_we;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_alu_res;
  logic [4:0]      mem_l_mask;
  logic [3:0]      mem_byte_we;
  logic            mem_req_rf;
  logic [RW-1:0]   mem_rf_waddr;
  logic            dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
  logic [XLEN-1:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]      dbus_be;
  logic            mem_stall, mem_exp_flag;
  logic [RW-1:0]   mem_fw_rd_addr;
  logic [XLEN-1:0] mem_fw_data;
  logic            wb_valid, wb_req_rf;
  logic [RW-1:0]   wb_rf_waddr;
  logic [XLEN-1:0] wb_rf_wdata;

  mem_stage #(.XLEN(XLEN), .RF_ADDR_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .pipe_flush(pipe_flush), .mem_valid(mem_valid),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_l_mask(mem_l_mask),
    .mem_byte_we(mem_byte_we), .mem_wdata(mem_wdata), .mem_req_rf(mem_req_rf),
    .mem_rf_waddr(mem_rf_waddr), .mem_alu_res(mem_alu_res),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
    .dbus_rdata(dbus_rdata), .mem_stall(mem_stall), .mem_exp_flag(mem_exp_flag),
    .mem_fw_rd_addr(mem_fw_rd_addr), .mem_fw_data(mem_fw_data),
    .wb_valid(wb_valid), .wb_req_rf(wb_req_rf), .wb_rf_waddr(wb_rf_waddr),
    .wb_rf_wdata(wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0]   rd;
    logic            req_rf;
    logic [XLEN-1:0] data;
  } wb_t;

  typedef struct {
    int              kind;   // 0 ALU, 1 load, 2 store
    int              sub;    // load: LB LH LW LBU LHU; store: SB SH SW
    logic [XLEN-1:0] addr, wdata, alu, rdata;
    logic [RW-1:0]   rd;
    logic            req_rf;
    int              gnt_dly, rsp_dly;
  } ins_t;

  wb_t sb_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input int t, input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] v;
    int          sh;
    sh = 8 * int'(addr[1:0]);
    case (t)
      0: begin v = (rdata >> sh) & 32'hFF;  if (v >= 32'd128)   v = v - 32'd256;   end
      1: begin v = (rdata >> (addr[1] ? 16 : 0)) & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3: v = (rdata >> sh) & 32'hFF;
      4: v = (rdata >> (addr[1] ? 16 : 0)) & 32'hFFFF;
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_wdata(input int t, input logic [31:0] w);
    if (t == 0)      return (w & 32'hFF) * 32'h0101_0101;
    else if (t == 1) return (w & 32'hFFFF) * 32'h0001_0001;
    else             return w;
  endfunction

  function automatic logic [3:0] ref_be(input int t, input logic [31:0] addr);
    if (t == 0)      return 4'b0001 << addr[1:0];
    else if (t == 1) return addr[1] ? 4'b1100 : 4'b0011;
    else             return 4'b1111;
  endfunction

  function automatic logic ref_misalign(input ins_t in);
`ifdef MEM_MISALIGN_EXP_EN
    int a;
    a = int'(in.addr[1:0]);
    if (in.kind == 1) return ((in.sub == 1 || in.sub == 4) && (a % 2 != 0)) || (in.sub == 2 && a != 0);
    if (in.kind == 2) return (in.sub == 1 && (a % 2 != 0)) || (in.sub == 2 && a != 0);
    return 1'b0;
`else
    return (in.kind < 0);
`endif
  endfunction

  function automatic ins_t mk(input int kind, input int sub, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic [RW-1:0] rd, input logic req_rf,
                              input int g, input int r);
    ins_t i;
    i.kind = kind; i.sub = sub; i.addr = addr; i.wdata = wdata; i.alu = 32'h5A5A_0000 + addr;
    i.rdata = rdata; i.rd = rd; i.req_rf = req_rf; i.gnt_dly = g; i.rsp_dly = r;
    return i;
  endfunction

  task automatic present(input ins_t in);
    mem_valid    = 1'b1;
    mem_re       = (in.kind == 1);
    mem_we       = (in.kind == 2);
    mem_addr     = in.addr;
    mem_l_mask   = (in.kind == 1) ? 5'(1 << in.sub) : 5'b0;
    mem_byte_we  = (in.kind == 2) ? ref_be(in.sub, in.addr) : 4'b0;
    mem_wdata    = in.wdata;
    mem_req_rf   = in.req_rf;
    mem_rf_waddr = in.rd;
    mem_alu_res  = in.alu;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the completing edge.
  task automatic run(input ins_t in);
    wb_t e;
    logic mis;
    present(in);
    pipe_flush  = 1'b0;
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'b0;
    dbus_rdata  = $urandom;
    mis = ref_misalign(in);
    e.rd = in.rd; e.req_rf = in.req_rf;
    e.data = (in.kind == 1) ? ref_load(in.sub, in.addr, in.rdata) : in.alu;
    if (in.kind == 0 || mis) begin
      if (!mis) sb_q.push_back(e);
      #3;
      check("stall_nomem", 32'(mem_stall), 32'd0);
      check("req_nomem", 32'(dbus_req), 32'd0);
      check("exp_flag", 32'(mem_exp_flag), 32'(mis));
      check("fw_data", mem_fw_data, in.alu);
      @(posedge clk); #1;
    end else begin
      sb_q.push_back(e);
      for (int k = 0; k <= in.gnt_dly; k++) begin
        dbus_gnt = (k == in.gnt_dly);
        #3;
        check("req", 32'(dbus_req), 32'd1);
        check("req_we", 32'(dbus_we), 32'(in.kind == 2));
        check("req_addr", dbus_addr, in.addr & 32'hFFFF_FFFC);
        check("req_be", 32'(dbus_be), 32'(mem_byte_we));
        if (in.kind == 2) check("req_wdata", dbus_wdata, ref_wdata(in.sub, in.wdata));
        check("stall_req", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
      end
      dbus_gnt = 1'b0;
      for (int k = 0; k < in.rsp_dly; k++) begin
        #3;
        check("req_after_gnt", 32'(dbus_req), 32'd0);
        check("stall_wait_rsp", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
      end
      dbus_rvalid = 1'b1;
      dbus_rdata  = in.rdata;
      #3;
      check("stall_rsp", 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      dbus_rvalid = 1'b0;
    end
    idle_inputs();
  endtask

  // Monitor: every write-back entry must match the oldest expectation.
  always @(negedge clk) begin
    wb_t e;
    if (!rst && wb_valid) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL wb_unexpected actual=rd%0d/%h required=none at %0t", wb_rf_waddr, wb_rf_wdata, $time);
      end else begin
        e = sb_q.pop_front();
        check("wb_rd", 32'(wb_rf_waddr), 32'(e.rd));
        check("wb_req_rf", 32'(wb_req_rf), 32'(e.req_rf));
        check("wb_data", wb_rf_wdata, e.data);
      end
    end
  end

  initial begin
    ins_t r;
    rst = 1'b1; pipe_flush = 1'b0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
    mem_addr = '0; mem_wdata = '0; mem_alu_res = '0; mem_l_mask = '0; mem_byte_we = '0;
    mem_req_rf = 1'b0; mem_rf_waddr = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #4;
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_req_rf", 32'(wb_req_rf), 32'd0);
    check("rst_wb_waddr", 32'(wb_rf_waddr), 32'd0);
    check("rst_wb_wdata", wb_rf_wdata, 32'd0);
    check("rst_req", 32'(dbus_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run(mk(1, 2, 32'h100, 32'h0, 32'hDEAD_BEEF, 5'd5, 1'b1, 0, 0));
    run(mk(1, 0, 32'h103, 32'h0, 32'h8011_2233, 5'd6, 1'b1, 0, 0));
    run(mk(1, 3, 32'h103, 32'h0, 32'h8011_2233, 5'd7, 1'b1, 0, 1));
    run(mk(1, 4, 32'h102, 32'h0, 32'h8011_2233, 5'd8, 1'b1, 1, 0));
    run(mk(2, 0, 32'h101, 32'h0000_00AB, 32'h0, 5'd0, 1'b0, 0, 0));
    run(mk(0, 0, 32'h40, 32'h0, 32'h0, 5'd9, 1'b1, 0, 0));
    run(mk(1, 2, 32'h204, 32'h0, 32'h1234_5678, 5'd10, 1'b1, 3, 2));
    run(mk(1, 2, 32'h102, 32'h0, 32'hCAFE_F00D, 5'd11, 1'b1, 0, 0));

    // Flush while waiting for the response: drain, then a new load completes.
    r = mk(1, 2, 32'h300, 32'h0, 32'h0, 5'd12, 1'b1, 0, 0);
    present(r);
    dbus_gnt = 1'b1;
    #3 check("fl_req", 32'(dbus_req), 32'd1);
    @(posedge clk); #1;
    dbus_gnt = 1'b0; pipe_flush = 1'b1;
    #3 check("fl_stall_rsp", 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    pipe_flush = 1'b0;
    r = mk(1, 0, 32'h301, 32'h0, 32'h0000_F700, 5'd13, 1'b1, 0, 0);
    present(r);
    #3 check("drain_no_req", 32'(dbus_req), 32'd0);
    check("drain_stall", 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    dbus_rvalid = 1'b1; dbus_rdata = 32'hBAD0_BAD0;
    #3 check("drain_rsp_no_req", 32'(dbus_req), 32'd0);
    check("drain_rsp_stall", 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    dbus_rvalid = 1'b0;
    run(r);

    // Flush while waiting for the grant drops the request.
    r = mk(2, 2, 32'h400, 32'h1111_2222, 32'h0, 5'd0, 1'b0, 0, 0);
    present(r);
    #3 check("fg_req", 32'(dbus_req), 32'd1);
    @(posedge clk); #1;
    pipe_flush = 1'b1;
    #3 check("fg_drop_req", 32'(dbus_req), 32'd0);
    check("fg_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    pipe_flush = 1'b0;
    idle_inputs();
    #3 check("fg_idle_req", 32'(dbus_req), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of a load; the late response must be ignored.
    r = mk(1, 2, 32'h500, 32'h0, 32'h0, 5'd14, 1'b1, 0, 0);
    present(r);
    dbus_gnt = 1'b1;
    @(posedge clk); #1;
    dbus_gnt = 1'b0; rst = 1'b1;
    idle_inputs();
    #3 check("mrst_req", 32'(dbus_req), 32'd0);
    check("mrst_wb_valid", 32'(wb_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'hFFFF_0000;
    #3 check("mrst_stale_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    dbus_rvalid = 1'b0;
    run(mk(1, 1, 32'h512, 32'h0, 32'h9ABC_1234, 5'd15, 1'b1, 0, 0));

    for (int n = 0; n < 200; n++) begin
      r.kind    = int'($urandom_range(0, 2));
      r.sub     = (r.kind == 1) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 2));
      r.addr    = 32'h1000 + 32'($urandom_range(0, 4095));
      r.wdata   = $urandom;
      r.alu     = $urandom;
      r.rdata   = $urandom;
      r.rd      = 5'($urandom_range(0, 31));
      r.req_rf  = (r.kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      r.gnt_dly = int'($urandom_range(0, 3));
      r.rsp_dly = int'($urandom_range(0, 3));
      run(r);
    end

    repeat (3) @(posedge clk);
    #1 check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
